// File: rtl/square_f32.sv
// square_f32: iterative binary32 squarer returning x*|x| (sign preserved).
// Shift-add mantissa multiplier retiring BITS_PER_CYCLE multiplier bits per
// cycle, followed by normalise and round-to-nearest-even stages.
// Denormal inputs and outputs are flushed to signed zero.
module square_f32 #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    output logic        busy,
    output logic        rdy,
    output logic [31:0] sq
);

    localparam int NCYC = 24 / BITS_PER_CYCLE;

    typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;

    state_t             state, state_nx;
    logic [31:0]        a_r;
    logic               sgn;
    logic [23:0]        mb;          // multiplier bits still to retire, LSB first
    logic [47:0]        ma_sh;       // multiplicand aligned to the current bit position
    logic [47:0]        p;           // product accumulator
    logic [47:0]        mul_sum;
    logic signed [9:0]  eb;          // biased result exponent, may go out of range
    logic signed [9:0]  eb_rnd;
    logic [4:0]         cnt;
    logic [23:0]        sig;
    logic [23:0]        sig_rnd;
    logic [24:0]        rsum;
    logic               guard, sticky;
    logic               special;
    logic               is_special;

    // Round-to-nearest-even on a 24-bit significand; bit 24 is the carry out.
    function automatic logic [24:0] round_rne(input logic [23:0] s, input logic g, input logic st);
        return {1'b0, s} + {24'h0, g & (st | s[0])};
    endfunction

    // Pack with saturation to Inf on overflow and flush to zero on underflow.
    function automatic logic [31:0] pack_sat(input logic sg, input logic signed [9:0] e,
                                             input logic [23:0] s);
        if (e >= 10'sd255)
            return {sg, 8'hFF, 23'h0};
        else if (e <= 10'sd0)
            return {sg, 31'h0};
        else
            return {sg, e[7:0], s[22:0]};
    endfunction

    assign is_special = (a_r[30:23] == 8'hFF) || (a_r[30:23] == 8'h00);

    // Partial products for the next BITS_PER_CYCLE multiplier bits.
    always_comb begin
        mul_sum = p;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mb[k])
                mul_sum = mul_sum + (ma_sh << k);
        end
    end

    // Rounded significand and exponent, renormalised on carry out.
    always_comb begin
        rsum = round_rne(sig, guard, sticky);
        if (rsum[24]) begin
            sig_rnd = 24'h800000;
            eb_rnd  = eb + 10'sd1;
        end else begin
            sig_rnd = rsum[23:0];
            eb_rnd  = eb;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; specials pass through ROUND untouched so they finish in 2 cycles.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = UNPACK;
            UNPACK:     state_nx = is_special ? ROUND : MUL;
            MUL:        if (cnt == 5'(NCYC - 1)) state_nx = NORM;
            NORM:       state_nx = ROUND;
            ROUND:      state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r     <= '0;
            sgn     <= 1'b0;
            mb      <= '0;
            ma_sh   <= '0;
            p       <= '0;
            eb      <= '0;
            cnt     <= '0;
            sig     <= '0;
            guard   <= 1'b0;
            sticky  <= 1'b0;
            special <= 1'b0;
            busy    <= 1'b0;
            rdy     <= 1'b0;
            sq      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r  <= a;
                        rdy  <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                UNPACK: begin
                    sgn     <= a_r[31];
                    mb      <= {1'b1, a_r[22:0]};
                    ma_sh   <= {24'h0, 1'b1, a_r[22:0]};
                    p       <= '0;
                    cnt     <= '0;
                    eb      <= $signed({1'b0, a_r[30:23], 1'b0}) - 10'sd127;
                    special <= is_special;
                    if (a_r[30:23] == 8'hFF)
                        sq <= a_r;
                    else if (a_r[30:23] == 8'h00)
                        sq <= {a_r[31], 31'h0};
                end
                MUL: begin
                    p     <= mul_sum;
                    ma_sh <= ma_sh << BITS_PER_CYCLE;
                    mb    <= mb >> BITS_PER_CYCLE;
                    cnt   <= cnt + 5'd1;
                end
                NORM: begin
                    if (p[47]) begin
                        eb     <= eb + 10'sd1;
                        sig    <= p[47:24];
                        guard  <= p[23];
                        sticky <= |p[22:0];
                    end else begin
                        sig    <= p[46:23];
                        guard  <= p[22];
                        sticky <= |p[21:0];
                    end
                end
                ROUND: begin
                    if (!special)
                        sq <= pack_sat(sgn, eb_rnd, sig_rnd);
                    busy <= 1'b0;
                    rdy  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
